csr_access_unit: RTL and testbench
==================================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The block SHALL have parameter CSR_ADDRESS_WIDTH, default 12, meaning CSR address width (only 12 supported).
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request to execute one CSR instruction; sampled only in IDLE.
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- csrAddress  in  12  target CSR.
- rs1Index  in  5  rs1 index, or zimm for the immediate forms.
- rdIndex  in  5  destination register index.
- rs1Data  in  32  rs1 value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  valid with done; the instruction raised an illegal-instruction trap.
- rdWriteEnable  out  1  valid with done; writeback of the old CSR value.
- rdData  out  32  old CSR value; valid with done.
- csrReadEnable  out  1  CSR read strobe.
- csrReadAddress  out  12  CSR read address.
- csrReadData  in  32  combinational read data from the CSR file.
- csrWriteEnable  out  1  CSR write strobe.
- csrWriteAddress  out  12  CSR write address.
- csrWriteData  out  32  CSR write value.

Function
REQ-003 The block SHALL implement FSM states IDLE, READ, WRITE, DONE, held in a registered state; all outputs are decoded from registered state only (Moore).
REQ-004 In IDLE, start=1 SHALL latch funct3, csrAddress, rs1Index, rdIndex and rs1Data; the source operand is rs1Data for funct3[2]=0, otherwise {27'b0, zimm}.
REQ-005 doRead SHALL be 1 for RS/RC/RSI/RCI, and 1 for RW/RWI only when rdIndex!=0.
REQ-006 doWrite SHALL be 1 for RW/RWI, and 1 for RS/RC/RSI/RCI only when rs1Index!=0.
REQ-007 From IDLE with start: illegal funct3 -> DONE with illegal=1; else doRead -> READ; else -> WRITE.
REQ-008 READ SHALL assert csrReadEnable=1 and csrReadAddress=latched address for exactly one cycle and capture csrReadData into oldValue at the cycle end; next state is WRITE if doWrite, else DONE.
REQ-009 WRITE SHALL assert csrWriteEnable=1 and csrWriteAddress=latched address for exactly one cycle, with csrWriteData = src (RW), oldValue|src (RS), or oldValue&~src (RC); next state is DONE.
REQ-010 DONE SHALL pulse done=1 for one cycle, then return to IDLE; rdWriteEnable=1 iff a READ occurred, rdIndex!=0 and illegal=0; rdData=oldValue.
REQ-011 Latency from the start edge to done SHALL be: 3 cycles for read+write, 2 cycles for read-only or write-only, 1 cycle for illegal.
REQ-012 Address and data outputs SHALL be 0 whenever their strobe is low.
REQ-013 start while busy SHALL be ignored and not queued; start in the DONE cycle is also ignored.
REQ-014 The block SHALL issue at most one csrReadEnable and one csrWriteEnable per accepted start.
REQ-015 When illegal=1, the block SHALL issue no CSR strobe.

Reset
REQ-016 rst=0 SHALL immediately force state=IDLE, oldValue=0 and all outputs to 0, including mid-operation; an aborted WRITE SHALL deassert csrWriteEnable asynchronously.
REQ-017 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-018 With macro CSR_ACCESS_READONLY_CHECK_EN defined, an accepted start with doWrite=1 and csrAddress[11:10]==2'b11 SHALL go IDLE -> DONE with illegal=1 and no strobes.
REQ-019 Without CSR_ACCESS_READONLY_CHECK_EN, that write SHALL be issued normally and illegal SHALL depend on funct3 only.

Verification
REQ-020 The bench SHALL cover: CSRRS, addr 0x340, CSR=0x0000_00F0, rs1Index=5, rs1Data=0x0F -> READ then WRITE 0x0000_00FF; done 3 cycles after start; rdData=0x0000_00F0.
REQ-021 The bench SHALL cover: CSRRW, rdIndex=0, rs1Data=0x1234_5678, addr 0x305 -> no csrReadEnable; single write of 0x1234_5678; done 2 cycles after start; rdWriteEnable=0.
REQ-022 The bench SHALL cover: CSRRCI, zimm=0, addr 0xC00 -> read only, no write; rdData=cycle value; no illegal, in both macro builds.
REQ-023 The bench SHALL cover: CSRRW to 0xF11 with rdIndex=1 -> with macro, done+illegal 1 cycle after start and zero strobes; without macro, read and write issued.
REQ-024 The bench SHALL cover: funct3=100 -> done=1 and illegal=1 after 1 cycle, no strobes; a second start while busy -> ignored, exactly one done.
REQ-025 The bench SHALL cover: rst=0 asserted during WRITE -> csrWriteEnable drops without waiting for a clock edge; no done; after release, a new CSRRS completes normally.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr instruction (CSRRW/RS/RC and the
// immediate forms) as IDLE -> [READ] -> [WRITE] -> DONE against an external
// CSR file with a combinational read port and a strobed write port.
// All outputs are decoded from registered state, so they fall to 0 as soon as
// the asynchronous active-low reset is applied.
// Optional build macro: CSR_ACCESS_READONLY_CHECK_EN. When it is defined,
// writes to the read-only CSR region (address[11:10] == 2'b11) trap as illegal.
module csr_access_unit #(
    parameter int CSR_ADDRESS_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2:0]                   funct3,
    input  logic [CSR_ADDRESS_WIDTH-1:0] csrAddress,
    input  logic [4:0]                   rs1Index,
    input  logic [4:0]                   rdIndex,
    input  logic [31:0]                  rs1Data,
    output logic                         busy,
    output logic                         done,
    output logic                         illegal,
    output logic                         rdWriteEnable,
    output logic [31:0]                  rdData,
    output logic                         csrReadEnable,
    output logic [CSR_ADDRESS_WIDTH-1:0] csrReadAddress,
    input  logic [31:0]                  csrReadData,
    output logic                         csrWriteEnable,
    output logic [CSR_ADDRESS_WIDTH-1:0] csrWriteAddress,
    output logic [31:0]                  csrWriteData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e                         state_q, state_d;
    logic [1:0]                     op_q, op_d;       // 01 write, 10 set, 11 clear
    logic [CSR_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]                    src_q, src_d;
    logic [31:0]                    old_q, old_d;
    logic                           wr_q, wr_d;       // instruction writes the CSR
    logic                           ill_q, ill_d;
    logic                           rd_q, rd_d;       // a READ cycle actually happened
    logic                           rdnz_q, rdnz_d;   // destination is not x0

    logic do_read, do_write, ro_trap, ill_start;
    logic [31:0] wdata;

    // Decode of the incoming instruction; only consulted when a start is accepted.
    always_comb begin
        do_read  = (funct3[1:0] == 2'b01) ? (rdIndex != 5'd0) : 1'b1;
        do_write = (funct3[1:0] == 2'b01) ? 1'b1 : (rs1Index != 5'd0);
`ifdef CSR_ACCESS_READONLY_CHECK_EN
        ro_trap  = do_write && (csrAddress[CSR_ADDRESS_WIDTH-1 -: 2] == 2'b11);
`else
        ro_trap  = 1'b0;
`endif
        ill_start = (funct3[1:0] == 2'b00) || ro_trap;
    end

    // Next-state and operand capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        src_d   = src_q;
        old_d   = old_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        rd_d    = rd_q;
        rdnz_d  = rdnz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = funct3[1:0];
                    addr_d  = csrAddress;
                    src_d   = funct3[2] ? {27'b0, rs1Index} : rs1Data;
                    old_d   = 32'd0;
                    rd_d    = 1'b0;
                    wr_d    = do_write;
                    rdnz_d  = (rdIndex != 5'd0);
                    ill_d   = ill_start;
                    state_d = ill_start ? DONE : (do_read ? READ : WRITE);
                end
            end
            READ: begin
                old_d   = csrReadData;
                rd_d    = 1'b1;
                state_d = wr_q ? WRITE : DONE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers; reset clears everything so outputs drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            addr_q  <= '0;
            src_q   <= 32'd0;
            old_q   <= 32'd0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            rd_q    <= 1'b0;
            rdnz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            old_q   <= old_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            rd_q    <= rd_d;
            rdnz_q  <= rdnz_d;
        end
    end

    // Write value from the latched operation.
    always_comb begin
        unique case (op_q)
            2'b01:   wdata = src_q;
            2'b10:   wdata = old_q | src_q;
            default: wdata = old_q & ~src_q;
        endcase
    end

    // Moore outputs; address/data buses are zero whenever their strobe is low.
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign illegal         = done & ill_q;
    assign rdWriteEnable   = done & rd_q & rdnz_q & ~ill_q;
    assign rdData          = done ? old_q : 32'd0;
    assign csrReadEnable   = (state_q == READ);
    assign csrReadAddress  = csrReadEnable ? addr_q : '0;
    assign csrWriteEnable  = (state_q == WRITE);
    assign csrWriteAddress = csrWriteEnable ? addr_q : '0;
    assign csrWriteData    = csrWriteEnable ? wdata : 32'd0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a CSR file model serves the DUT, while a
// transaction-level reference model predicts, per accepted instruction, the
// sequence of cycles (read strobe, write strobe, done) and their values.
// Every cycle the DUT outputs are compared with the predicted cycle.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [11:0] csrAddress = 12'd0;
    logic [4:0]  rs1Index = 5'd0;
    logic [4:0]  rdIndex = 5'd0;
    logic [31:0] rs1Data = 32'd0;
    logic        busy, done, illegal, rdWriteEnable;
    logic [31:0] rdData;
    logic        csrReadEnable, csrWriteEnable;
    logic [11:0] csrReadAddress, csrWriteAddress;
    logic [31:0] csrReadData, csrWriteData;

    always #5 clk = ~clk;

    csr_access_unit #(.CSR_ADDRESS_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .csrAddress(csrAddress), .rs1Index(rs1Index), .rdIndex(rdIndex),
        .rs1Data(rs1Data), .busy(busy), .done(done), .illegal(illegal),
        .rdWriteEnable(rdWriteEnable), .rdData(rdData),
        .csrReadEnable(csrReadEnable), .csrReadAddress(csrReadAddress),
        .csrReadData(csrReadData), .csrWriteEnable(csrWriteEnable),
        .csrWriteAddress(csrWriteAddress), .csrWriteData(csrWriteData)
    );

    function automatic logic [31:0] init_val(input int i);
        logic [11:0] a;
        a = i[11:0];
        return {20'hC5A00, a};
    endfunction

    // CSR file seen by the DUT
    logic [31:0] env_csr [4096];
    bit          env_init;
    assign csrReadData = env_csr[csrReadAddress];
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 4096; i++) env_csr[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (csrWriteEnable) begin
            env_csr[csrWriteAddress] <= csrWriteData;
        end
    end

    typedef struct packed {
        logic        busy, done, ill, rdwe;
        logic [31:0] rdd;
        logic        re;
        logic [11:0] ra;
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
    } obs_t;

    logic [31:0] ref_csr [4096];
    obs_t        exp_q[$];
    bit          cur_busy;
    int          checks, failures, cyc, t0;
    int          rd_cnt, wr_cnt, done_cnt, lat;
    logic [31:0] last_wd, last_rdd;
    logic        last_ill, last_rdwe;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Reference model: expected cycles of one accepted instruction.
    task automatic model_push(input logic [2:0] f, input logic [11:0] a,
                              input logic [4:0] r1, input logic [4:0] rd, input logic [31:0] d);
        obs_t e;
        logic [31:0] src, old, nv;
        bit ill, dr, dw;
        logic [1:0] top;
        src = f[2] ? {27'b0, r1} : d;
        dr  = (f[1:0] == 2'b01) ? (rd != 0) : 1'b1;
        dw  = (f[1:0] == 2'b01) ? 1'b1 : (r1 != 0);
        ill = (f[1:0] == 2'b00);
        top = a[11:10];
`ifdef CSR_ACCESS_READONLY_CHECK_EN
        if (dw && top == 2'b11) ill = 1'b1;
`endif
        if (top == 2'b11) ; // region noted above only when the check is built
        if (ill) begin
            e = '0; e.busy = 1; e.done = 1; e.ill = 1;
            exp_q.push_back(e);
            return;
        end
        old = dr ? ref_csr[a] : 32'd0;
        case (f[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        if (dr) begin
            e = '0; e.busy = 1; e.re = 1; e.ra = a;
            exp_q.push_back(e);
        end
        if (dw) begin
            e = '0; e.busy = 1; e.we = 1; e.wa = a; e.wd = nv;
            exp_q.push_back(e);
            ref_csr[a] = nv;
        end
        e = '0; e.busy = 1; e.done = 1; e.rdwe = dr && (rd != 0); e.rdd = old;
        exp_q.push_back(e);
    endtask

    // Advance one cycle and compare the DUT against the predicted cycle.
    task automatic tick();
        obs_t o, e;
        @(posedge clk);
        #1;
        cyc++;
        o.busy = busy; o.done = done; o.ill = illegal; o.rdwe = rdWriteEnable;
        o.rdd = rdData; o.re = csrReadEnable; o.ra = csrReadAddress;
        o.we = csrWriteEnable; o.wa = csrWriteAddress; o.wd = csrWriteData;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        cur_busy = e.busy;
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, o, e);
        end
        if (o.re) rd_cnt++;
        if (o.we) begin wr_cnt++; last_wd = o.wd; end
        if (o.done) begin
            done_cnt++; lat = cyc - t0;
            last_rdd = o.rdd; last_ill = o.ill; last_rdwe = o.rdwe;
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [11:0] a,
                         input logic [4:0] r1, input logic [4:0] rd, input logic [31:0] d);
        start = 1'b1; funct3 = f; csrAddress = a; rs1Index = r1; rdIndex = rd; rs1Data = d;
        if (exp_q.size() == 0 && !cur_busy) begin
            t0 = cyc;
            model_push(f, a, r1, rd, d);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; lat = -1;
        last_wd = 0; last_rdd = 0; last_ill = 0; last_rdwe = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 12 && (exp_q.size() != 0 || cur_busy); i++) tick();
        chk("complete", {31'd0, (exp_q.size() != 0 || cur_busy)}, 32'd0);
    endtask

    task automatic run_hold(input logic [2:0] f, input logic [11:0] a, input logic [4:0] r1,
                            input logic [4:0] rd, input logic [31:0] d, input int hold);
        clear_stats();
        for (int h = 0; h < hold; h++) begin
            issue(f, a, r1, rd, d);
            tick();
        end
        start = 1'b0;
        wait_idle();
    endtask

    task automatic run(input logic [2:0] f, input logic [11:0] a, input logic [4:0] r1,
                       input logic [4:0] rd, input logic [31:0] d);
        run_hold(f, a, r1, rd, d, 1);
    endtask

    initial begin
        logic [31:0] saved;
        logic [11:0] addrs [6];
        addrs[0] = 12'h340; addrs[1] = 12'h305; addrs[2] = 12'hC00;
        addrs[3] = 12'hF11; addrs[4] = 12'h300; addrs[5] = 12'h7C0;
        for (int i = 0; i < 4096; i++) ref_csr[i] = init_val(i);
        checks = 0; failures = 0; cyc = 0; t0 = 0; cur_busy = 0;
        clear_stats();

        // reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_strobes", {30'd0, csrReadEnable, csrWriteEnable}, 0);
        chk("rst_rddata", rdData, 0);
        repeat (3) tick();
        rst = 1'b1;

        // CSRRS read+write
        run(3'b001, 12'h340, 5'd1, 5'd0, 32'h0000_00F0);
        run(3'b010, 12'h340, 5'd5, 5'd2, 32'h0000_000F);
        chk("rs_reads", rd_cnt, 1);
        chk("rs_writes", wr_cnt, 1);
        chk("rs_wdata", last_wd, 32'h0000_00FF);
        chk("rs_latency", lat, 3);
        chk("rs_rddata", last_rdd, 32'h0000_00F0);
        chk("rs_rdwe", {31'd0, last_rdwe}, 1);

        // CSRRW with rd=x0: write only
        run(3'b001, 12'h305, 5'd7, 5'd0, 32'h1234_5678);
        chk("rw_reads", rd_cnt, 0);
        chk("rw_writes", wr_cnt, 1);
        chk("rw_wdata", last_wd, 32'h1234_5678);
        chk("rw_latency", lat, 2);
        chk("rw_rdwe", {31'd0, last_rdwe}, 0);

        // CSRRCI zimm=0 on a read-only counter: read only
        run(3'b111, 12'hC00, 5'd0, 5'd3, 32'hFFFF_FFFF);
        chk("rci_reads", rd_cnt, 1);
        chk("rci_writes", wr_cnt, 0);
        chk("rci_rddata", last_rdd, 32'hC5A0_0C00);
        chk("rci_illegal", {31'd0, last_ill}, 0);
        chk("rci_latency", lat, 2);

        // CSRRW to read-only region
        run(3'b001, 12'hF11, 5'd4, 5'd1, 32'hDEAD_0000);
`ifdef CSR_ACCESS_READONLY_CHECK_EN
        chk("ro_latency", lat, 1);
        chk("ro_illegal", {31'd0, last_ill}, 1);
        chk("ro_strobes", rd_cnt + wr_cnt, 0);
`else
        chk("ro_latency", lat, 3);
        chk("ro_illegal", {31'd0, last_ill}, 0);
        chk("ro_reads", rd_cnt, 1);
        chk("ro_writes", wr_cnt, 1);
        chk("ro_rddata", last_rdd, 32'hC5A0_0F11);
`endif

        // illegal funct3, start held through the DONE cycle
        run_hold(3'b100, 12'h340, 5'd1, 5'd1, 32'h1, 2);
        chk("ill_done_cnt", done_cnt, 1);
        chk("ill_flag", {31'd0, last_ill}, 1);
        chk("ill_latency", lat, 1);
        chk("ill_strobes", rd_cnt + wr_cnt, 0);

        // start held while busy: one instruction only
        run_hold(3'b010, 12'h300, 5'd1, 5'd1, 32'h10, 3);
        chk("busy_done_cnt", done_cnt, 1);
        chk("busy_writes", wr_cnt, 1);

        // reset during WRITE
        clear_stats();
        saved = ref_csr[12'h340];
        issue(3'b010, 12'h340, 5'd5, 5'd2, 32'h0000_0300);
        tick();
        start = 1'b0;
        tick();
        chk("we_before_rst", {31'd0, csrWriteEnable}, 1);
        #2 rst = 1'b0;
        #1;
        chk("we_async_drop", {31'd0, csrWriteEnable}, 0);
        chk("busy_async_drop", {31'd0, busy}, 0);
        exp_q.delete();
        cur_busy = 0;
        ref_csr[12'h340] = saved;
        repeat (2) tick();
        chk("rst_no_done", done_cnt, 0);
        rst = 1'b1;
        run(3'b010, 12'h340, 5'd6, 5'd3, 32'h0000_0100);
        chk("post_rst_rddata", last_rdd, 32'h0000_00FF);
        chk("post_rst_wdata", last_wd, 32'h0000_01FF);
        chk("post_rst_latency", lat, 3);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  f;
            logic [11:0] a;
            logic [4:0]  r1, rd;
            logic [31:0] d;
            int hold;
            f    = 3'($urandom_range(0, 7));
            a    = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 5)];
            r1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d    = $urandom;
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                issue(f, a, r1, rd, d);
                tick();
            end
            start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
